// File: rtl/regfile_pkg.sv
// Shared types, sizes and read-mux helpers for the ARM pipeline register file.
package regfile_pkg;

  localparam int NUM_REGS   = 32;
  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 5;
  localparam int ZERO_REG   = 31;

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;
  typedef logic [NUM_REGS-1:0][DATA_WIDTH-1:0] reg_file_t;

  // Basic 4:1 mux cell used to build the read tree.
  function automatic reg_data_t mux4(input reg_data_t d0, input reg_data_t d1,
                                     input reg_data_t d2, input reg_data_t d3,
                                     input logic [1:0] sel);
    reg_data_t y;
    case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      2'd3:    y = d3;
      default: y = d0;
    endcase
    return y;
  endfunction

  // 32:1 read path: two levels of 4:1 muxes and a final 2:1 on addr[4].
  // The zero register is forced to 0 here, independent of stored contents.
  function automatic reg_data_t read_tree(input reg_file_t regs, input reg_addr_t addr);
    reg_data_t lvl1 [8];
    reg_data_t lvl2 [2];
    reg_data_t y;
    for (int i = 0; i < 8; i++) begin
      lvl1[i] = mux4(regs[4*i], regs[4*i+1], regs[4*i+2], regs[4*i+3], addr[1:0]);
    end
    for (int j = 0; j < 2; j++) begin
      lvl2[j] = mux4(lvl1[4*j], lvl1[4*j+1], lvl1[4*j+2], lvl1[4*j+3], addr[3:2]);
    end
    if (addr == reg_addr_t'(ZERO_REG)) begin
      y = {DATA_WIDTH{1'b0}};
    end else begin
      y = addr[4] ? lvl2[1] : lvl2[0];
    end
    return y;
  endfunction

endpackage

// File: rtl/decoder5_32.sv
// 5-to-32 one-hot decoder with enable; all zeros when disabled.
module decoder5_32
  import regfile_pkg::*;
(
  input  logic                en,
  input  reg_addr_t           addr,
  output logic [NUM_REGS-1:0] onehot
);

  // Raise exactly one bit for the addressed register when enabled.
  always_comb begin
    onehot = {NUM_REGS{1'b0}};
    if (en) begin
      onehot[addr] = 1'b1;
    end else begin
      onehot = {NUM_REGS{1'b0}};
    end
  end

endmodule

// File: rtl/regfile_demux.sv
// Register file for the write-back stage: one write port steered by a one-hot
// decoder, two combinational read ports, X31 hard-wired to zero.
// Optional feature: define REGFILE_WRITE_BYPASS_EN to forward same-cycle
// write data to a read port addressing the register being written.
module regfile_demux #(
  parameter int NUM_REGS   = regfile_pkg::NUM_REGS,
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int ZERO_REG   = regfile_pkg::ZERO_REG
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [4:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [4:0]            rd_addr_a,
  input  logic [4:0]            rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  output logic [NUM_REGS-1:0]   wr_onehot,
  output logic                  wr_ack
);

  import regfile_pkg::*;

  // Mask that clears the zero-register bit of the decoded write enables.
  localparam logic [NUM_REGS-1:0] ZERO_MASK =
    ~({{(NUM_REGS-1){1'b0}}, 1'b1} << ZERO_REG);

  logic [NUM_REGS-1:0] dec_s;
  logic [NUM_REGS-1:0] we_s;
  logic                wr_accept_s;
  reg_file_t           regs_s;

  decoder5_32 u_dec (
    .en     (wr_en),
    .addr   (wr_addr),
    .onehot (dec_s)
  );

  // A write to the zero register never reaches storage nor the ack outputs.
  assign we_s        = dec_s & ZERO_MASK;
  assign wr_accept_s = |we_s;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    logic [DATA_WIDTH-1:0] q_r;

    // Enabled 64-bit register; reset wins over a same-cycle write.
    always_ff @(posedge clk) begin
      if (reset) begin
        q_r <= {DATA_WIDTH{1'b0}};
      end else if (we_s[i]) begin
        q_r <= wr_data;
      end else begin
        q_r <= q_r;
      end
    end

    assign regs_s[i] = q_r;
  end

  // Write status: one-hot of the accepted write and a one-cycle ack pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_onehot <= {NUM_REGS{1'b0}};
      wr_ack    <= 1'b0;
    end else begin
      wr_onehot <= we_s;
      wr_ack    <= wr_accept_s;
    end
  end

  // Read port A: mux tree, optionally overridden by the in-flight write.
  always_comb begin
    rd_data_a = read_tree(regs_s, rd_addr_a);
`ifdef REGFILE_WRITE_BYPASS_EN
    if (wr_accept_s && !reset && (rd_addr_a == wr_addr)) begin
      rd_data_a = wr_data;
    end else begin
      rd_data_a = read_tree(regs_s, rd_addr_a);
    end
`endif
  end

  // Read port B: identical to port A, fully independent.
  always_comb begin
    rd_data_b = read_tree(regs_s, rd_addr_b);
`ifdef REGFILE_WRITE_BYPASS_EN
    if (wr_accept_s && !reset && (rd_addr_b == wr_addr)) begin
      rd_data_b = wr_data;
    end else begin
      rd_data_b = read_tree(regs_s, rd_addr_b);
    end
`endif
  end

endmodule

// File: tb/tb_regfile_demux.sv
// Scoreboard bench for regfile_demux: directed vectors push expected outputs,
// a negedge monitor pops and compares them.
module tb_regfile_demux;

`ifdef REGFILE_WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [63:0] D5 = 64'h0123_4567_89AB_CDEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic [63:0] rd_data_a;
  logic [63:0] rd_data_b;
  logic [31:0] wr_onehot;
  logic        wr_ack;

  typedef struct packed {
    logic [31:0] step;
    logic [63:0] a;
    logic [63:0] b;
    logic [31:0] oh;
    logic        ack;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  always #5 clk = ~clk;

  regfile_demux dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .wr_onehot (wr_onehot),
    .wr_ack    (wr_ack)
  );

  task automatic cmp(input string name, input int s, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, s, act, exp);
    end
  endtask

  // Apply one cycle of stimulus just after the clock edge and queue its expectation.
  task automatic step(input logic rst, input logic we, input logic [4:0] wa, input logic [63:0] wd,
                      input logic [4:0] ra, input logic [4:0] rb, input logic chk,
                      input logic [63:0] ea, input logic [63:0] eb,
                      input logic [31:0] eoh, input logic eack);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = rst;
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
    rd_addr_a = ra;
    rd_addr_b = rb;
    if (chk) begin
      e.step = step_no;
      e.a    = ea;
      e.b    = eb;
      e.oh   = eoh;
      e.ack  = eack;
      sb_q.push_back(e);
    end
    step_no++;
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      cmp("rd_data_a", e.step, rd_data_a, e.a);
      cmp("rd_data_b", e.step, rd_data_b, e.b);
      cmp("wr_onehot", e.step, {32'd0, wr_onehot}, {32'd0, e.oh});
      cmp("wr_ack", e.step, {63'd0, wr_ack}, {63'd0, e.ack});
    end
  end

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 64'h0;
    rd_addr_a = 5'd0; rd_addr_b = 5'd0;

    // Reset, then preload a few registers.
    step(1'b1, 1'b0, 5'd0,  64'h0,    5'd0,  5'd0,  1'b0, 64'h0, 64'h0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 5'd0,  64'h0,    5'd0,  5'd31, 1'b1, 64'h0, 64'h0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 5'd0,  64'hA0A0, 5'd1,  5'd2,  1'b1, 64'h0, 64'h0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 5'd1,  64'hB1B1, 5'd0,  5'd30, 1'b1, 64'hA0A0, 64'h0, 32'h1, 1'b1);
    step(1'b0, 1'b1, 5'd30, 64'hC3C3, 5'd1,  5'd0,  1'b1, 64'hB1B1, 64'hA0A0, 32'h2, 1'b1);
    // Reset with preloaded registers clears everything.
    step(1'b1, 1'b0, 5'd0,  64'h0,    5'd30, 5'd1,  1'b1, 64'hC3C3, 64'hB1B1, 32'h4000_0000, 1'b1);
    step(1'b0, 1'b0, 5'd0,  64'h0,    5'd0,  5'd1,  1'b1, 64'h0, 64'h0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 5'd0,  64'h0,    5'd30, 5'd31, 1'b1, 64'h0, 64'h0, 32'h0, 1'b0);
    // Write X5, read it back; ack/onehot last one cycle.
    step(1'b0, 1'b1, 5'd5,  D5,       5'd5,  5'd31, 1'b1, BYP ? D5 : 64'h0, 64'h0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 5'd0,  64'h0,    5'd5,  5'd5,  1'b1, D5, D5, 32'h20, 1'b1);
    step(1'b0, 1'b0, 5'd0,  64'h0,    5'd5,  5'd31, 1'b1, D5, 64'h0, 32'h0, 1'b0);
    // Write to X31 is dropped.
    step(1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31, 1'b1, 64'h0, 64'h0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 5'd0,  64'h0,    5'd31, 5'd31, 1'b1, 64'h0, 64'h0, 32'h0, 1'b0);
    // Same-cycle write and read of X7.
    step(1'b0, 1'b1, 5'd7,  64'h11,   5'd0,  5'd0,  1'b1, 64'h0, 64'h0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 5'd7,  64'hAA,   5'd7,  5'd7,  1'b1, BYP ? 64'hAA : 64'h11, BYP ? 64'hAA : 64'h11, 32'h80, 1'b1);
    step(1'b0, 1'b0, 5'd0,  64'h0,    5'd5,  5'd7,  1'b1, D5, 64'hAA, 32'h80, 1'b1);
    // Back-to-back writes X1=1, X2=2, X1=3.
    step(1'b0, 1'b1, 5'd1,  64'h1,    5'd1,  5'd2,  1'b1, BYP ? 64'h1 : 64'h0, 64'h0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 5'd2,  64'h2,    5'd1,  5'd2,  1'b1, 64'h1, BYP ? 64'h2 : 64'h0, 32'h2, 1'b1);
    step(1'b0, 1'b1, 5'd1,  64'h3,    5'd1,  5'd2,  1'b1, BYP ? 64'h3 : 64'h1, 64'h2, 32'h4, 1'b1);
    step(1'b0, 1'b0, 5'd0,  64'h0,    5'd1,  5'd2,  1'b1, 64'h3, 64'h2, 32'h2, 1'b1);
    step(1'b0, 1'b0, 5'd0,  64'h0,    5'd1,  5'd2,  1'b1, 64'h3, 64'h2, 32'h0, 1'b0);
    // Reset in the same cycle as a write to X3 discards the write.
    step(1'b0, 1'b1, 5'd3,  64'h55,   5'd3,  5'd3,  1'b1, BYP ? 64'h55 : 64'h0, BYP ? 64'h55 : 64'h0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 5'd3,  64'h99,   5'd3,  5'd7,  1'b1, 64'h55, 64'hAA, 32'h8, 1'b1);
    step(1'b0, 1'b0, 5'd0,  64'h0,    5'd3,  5'd7,  1'b1, 64'h0, 64'h0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 5'd0,  64'h0,    5'd5,  5'd1,  1'b1, 64'h0, 64'h0, 32'h0, 1'b0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 5; k++) begin
      if (sb_q.size() > 0) begin
        @(negedge clk);
        #1;
      end
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
